// File: rtl/dco_code_ctrl.sv
// dco_code_ctrl: DCO switch-code controller (IDLE/ACQ/TRACK) with a track-mode hysteresis filter.
// Define SS_MOD_EN to compile in the triangle spread-spectrum modulator on the output code.
module dco_code_ctrl #(
  parameter int SW_W    = 8,
  parameter int SW_INIT = 128,
  parameter int HYST    = 2
) (
  input  logic            ref_clk,
  input  logic            reset,
  input  logic            freq_update,
  input  logic            freq_incr_decr,
  input  logic            fll_locked,
  input  logic            ss_en,
  input  logic [3:0]      ss_depth,
  input  logic [7:0]      ss_period,
  output logic [SW_W-1:0] sw,
  output logic            sw_valid,
  output logic            at_min,
  output logic            at_max
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACQ   = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  localparam int              HW        = (HYST < 2) ? 1 : $clog2(HYST + 1);
  localparam logic [HW-1:0]   HYST_C    = HW'(HYST);
  localparam logic [SW_W-1:0] CODE_MAX  = '1;
  localparam logic [SW_W-1:0] CODE_INIT = SW_W'(SW_INIT);
  localparam int              SUM_W     = SW_W + 2;

  logic [1:0]      r_state;
  logic [SW_W-1:0] r_base;
  logic [HW-1:0]   r_hcnt;
  logic            r_hdir;
  logic [SW_W-1:0] r_sw;
  logic            r_sw_valid;
  logic            r_at_min;
  logic            r_at_max;

  logic [1:0]        w_state_nxt;
  logic              w_step;
  logic [HW-1:0]     w_hcnt_run;
  logic [HW-1:0]     w_hcnt_nxt;
  logic              w_hdir_nxt;
  logic [SW_W-1:0]   w_base_nxt;
  logic signed [5:0] w_off_nxt;
  logic [SUM_W-1:0]  w_sum;
  logic [SW_W-1:0]   w_sw_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = ACQ;
      ACQ:     if (fll_locked) w_state_nxt = TRACK;
      TRACK:   if (!fll_locked) w_state_nxt = ACQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pulses are judged by the state being left, so a pulse on the lock edge uses the old rules.
  always_comb begin
    w_step     = 1'b0;
    w_hcnt_run = '0;
    w_hcnt_nxt = r_hcnt;
    w_hdir_nxt = r_hdir;
    if (freq_update) begin
      if (r_state == ACQ) begin
        w_step = 1'b1;
      end else if (r_state == TRACK) begin
        if ((r_hcnt == '0) || (r_hdir != freq_incr_decr)) begin
          w_hcnt_run = HW'(1);
        end else begin
          w_hcnt_run = r_hcnt + HW'(1);
        end
        w_hdir_nxt = freq_incr_decr;
        if (w_hcnt_run >= HYST_C) begin
          w_step     = 1'b1;
          w_hcnt_nxt = '0;
        end else begin
          w_hcnt_nxt = w_hcnt_run;
        end
      end
    end
    if (w_state_nxt != TRACK) begin
      w_hcnt_nxt = '0;
    end
  end

  always_comb begin
    w_base_nxt = r_base;
    if (w_step) begin
      if (freq_incr_decr) begin
        if (r_base != CODE_MAX) w_base_nxt = r_base + SW_W'(1);
      end else begin
        if (r_base != '0) w_base_nxt = r_base - SW_W'(1);
      end
    end
  end

`ifdef SS_MOD_EN
  logic signed [5:0] r_off;
  logic              r_ss_dir;
  logic [7:0]        r_per_cnt;

  logic              w_ss_run;
  logic signed [5:0] w_depth;
  logic              w_ss_dir_nxt;
  logic [7:0]        w_per_nxt;

  // Only modulate while settled in TRACK; the lock-in edge itself does not advance the phase.
  assign w_ss_run = ss_en && (r_state == TRACK) && (w_state_nxt == TRACK);
  assign w_depth  = $signed({2'b00, ss_depth});

  always_comb begin
    w_off_nxt    = '0;
    w_ss_dir_nxt = 1'b1;
    w_per_nxt    = '0;
    if (w_ss_run) begin
      w_off_nxt    = r_off;
      w_ss_dir_nxt = r_ss_dir;
      if (r_per_cnt >= ss_period) begin
        w_per_nxt = '0;
        if (ss_depth == 4'd0) begin
          w_off_nxt = '0;
        end else if (r_ss_dir) begin
          if (r_off >= w_depth) begin
            w_ss_dir_nxt = 1'b0;
            w_off_nxt    = r_off - 6'sd1;
          end else begin
            w_off_nxt = r_off + 6'sd1;
          end
        end else begin
          if (r_off <= -w_depth) begin
            w_ss_dir_nxt = 1'b1;
            w_off_nxt    = r_off + 6'sd1;
          end else begin
            w_off_nxt = r_off - 6'sd1;
          end
        end
      end else begin
        w_per_nxt = r_per_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      r_off     <= '0;
      r_ss_dir  <= 1'b1;
      r_per_cnt <= '0;
    end else begin
      r_off     <= w_off_nxt;
      r_ss_dir  <= w_ss_dir_nxt;
      r_per_cnt <= w_per_nxt;
    end
  end
`else
  logic w_unused_ss;

  assign w_off_nxt   = '0;
  assign w_unused_ss = ^{ss_en, ss_depth, ss_period};
`endif

  // Offset is added to the next base code so sw moves on the same edge as the base.
  assign w_sum = $signed({2'b00, w_base_nxt}) + SUM_W'(w_off_nxt);

  always_comb begin
    if (w_sum[SUM_W-1]) begin
      w_sw_nxt = '0;
    end else if (w_sum[SUM_W-2:SW_W] != '0) begin
      w_sw_nxt = CODE_MAX;
    end else begin
      w_sw_nxt = w_sum[SW_W-1:0];
    end
  end

  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_base     <= CODE_INIT;
      r_hcnt     <= '0;
      r_hdir     <= 1'b0;
      r_sw       <= CODE_INIT;
      r_sw_valid <= 1'b0;
      r_at_min   <= (CODE_INIT == '0);
      r_at_max   <= (CODE_INIT == CODE_MAX);
    end else begin
      r_state    <= w_state_nxt;
      r_base     <= w_base_nxt;
      r_hcnt     <= w_hcnt_nxt;
      r_hdir     <= w_hdir_nxt;
      r_sw       <= w_sw_nxt;
      r_sw_valid <= (w_state_nxt != IDLE);
      r_at_min   <= (w_base_nxt == '0);
      r_at_max   <= (w_base_nxt == CODE_MAX);
    end
  end

  assign sw       = r_sw;
  assign sw_valid = r_sw_valid;
  assign at_min   = r_at_min;
  assign at_max   = r_at_max;

endmodule

// File: tb/tb_dco_code_ctrl.sv
// Directed self-checking bench for dco_code_ctrl (SW_W=8, SW_INIT=128, HYST=2).
// Expected spread offsets follow SS_MOD_EN the same way the design build does.
module tb_dco_code_ctrl;

`ifdef SS_MOD_EN
  localparam int SS_ON = 1;
`else
  localparam int SS_ON = 0;
`endif

  logic       ref_clk = 1'b0;
  logic       reset = 1'b0;
  logic       freqUpdate = 1'b0;
  logic       freqIncrDecr = 1'b0;
  logic       fllLocked = 1'b0;
  logic       ssEn = 1'b0;
  logic [3:0] ssDepth = 4'd2;
  logic [7:0] ssPeriod = 8'd3;
  logic [7:0] sw;
  logic       swValid;
  logic       atMin;
  logic       atMax;

  int total = 0;
  int bad = 0;
  int triTbl [8] = '{0, 1, 2, 1, 0, -1, -2, -1};

  dco_code_ctrl #(.SW_W(8), .SW_INIT(128), .HYST(2)) dut (
    .ref_clk        (ref_clk),
    .reset          (reset),
    .freq_update    (freqUpdate),
    .freq_incr_decr (freqIncrDecr),
    .fll_locked     (fllLocked),
    .ss_en          (ssEn),
    .ss_depth       (ssDepth),
    .ss_period      (ssPeriod),
    .sw             (sw),
    .sw_valid       (swValid),
    .at_min         (atMin),
    .at_max         (atMax)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // One-cycle correction pulse; outputs are sampled 1ns after the edge that consumes it.
  task automatic applyStimulus(input logic dir);
    freqUpdate   = 1'b1;
    freqIncrDecr = dir;
    tick();
    freqUpdate   = 1'b0;
  endtask

  initial begin
    $display("[TB] start, SS_ON=%0d", SS_ON);

    // Reset state.
    #12;
    checkOutput("rst_sw", 32'(sw), 32'd128);
    checkOutput("rst_valid", 32'(swValid), 32'd0);
    checkOutput("rst_min", 32'(atMin), 32'd0);
    checkOutput("rst_max", 32'(atMax), 32'd0);

    // Release with a pulse pending: the IDLE cycle ignores it.
    reset        = 1'b1;
    freqUpdate   = 1'b1;
    freqIncrDecr = 1'b1;
    tick();
    freqUpdate = 1'b0;
    checkOutput("idle_ignore_sw", 32'(sw), 32'd128);
    checkOutput("acq_valid", 32'(swValid), 32'd1);

    // ACQ: every pulse moves the code on the next edge.
    applyStimulus(1'b1); checkOutput("acq_up1", 32'(sw), 32'd129);
    applyStimulus(1'b1); checkOutput("acq_up2", 32'(sw), 32'd130);
    applyStimulus(1'b1); checkOutput("acq_up3", 32'(sw), 32'd131);
    tick();              checkOutput("acq_hold", 32'(sw), 32'd131);
    checkOutput("acq_valid2", 32'(swValid), 32'd1);
    applyStimulus(1'b0); checkOutput("acq_dn", 32'(sw), 32'd130);
    applyStimulus(1'b1); checkOutput("acq_up4", 32'(sw), 32'd131);

    // Upper saturation.
    for (int i = 0; i < 123; i++) applyStimulus(1'b1);
    checkOutput("acq_254", 32'(sw), 32'd254);
    checkOutput("max_254", 32'(atMax), 32'd0);
    applyStimulus(1'b1); checkOutput("sat_255", 32'(sw), 32'd255);
    checkOutput("max_set", 32'(atMax), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1);
    checkOutput("sat_hold_255", 32'(sw), 32'd255);
    checkOutput("max_hold", 32'(atMax), 32'd1);

    // Lower saturation.
    for (int i = 0; i < 255; i++) applyStimulus(1'b0);
    checkOutput("sat_0", 32'(sw), 32'd0);
    checkOutput("min_set", 32'(atMin), 32'd1);
    checkOutput("max_clear", 32'(atMax), 32'd0);
    applyStimulus(1'b0); checkOutput("sat_hold_0", 32'(sw), 32'd0);
    for (int i = 0; i < 101; i++) applyStimulus(1'b1);
    checkOutput("acq_101", 32'(sw), 32'd101);
    checkOutput("min_clear", 32'(atMin), 32'd0);

    // Lock edge with a coincident down pulse: handled with ACQ rules.
    fllLocked = 1'b1;
    applyStimulus(1'b0); checkOutput("lock_edge_dn", 32'(sw), 32'd100);

    // TRACK hysteresis: up, down, down, up -> single decrement on the second down.
    applyStimulus(1'b1); checkOutput("hy_up", 32'(sw), 32'd100);
    applyStimulus(1'b0); checkOutput("hy_dn1", 32'(sw), 32'd100);
    applyStimulus(1'b0); checkOutput("hy_dn2", 32'(sw), 32'd99);
    applyStimulus(1'b1); checkOutput("hy_up1", 32'(sw), 32'd99);
    applyStimulus(1'b1); checkOutput("hy_up2", 32'(sw), 32'd100);
    checkOutput("track_valid", 32'(swValid), 32'd1);

    // Unlock edge with a pulse: TRACK rules (no step), and the run is discarded.
    fllLocked = 1'b0;
    applyStimulus(1'b1); checkOutput("unlock_edge_up", 32'(sw), 32'd100);
    fllLocked = 1'b1;
    tick();
    applyStimulus(1'b1); checkOutput("relock_up1", 32'(sw), 32'd100);
    applyStimulus(1'b1); checkOutput("relock_up2", 32'(sw), 32'd101);
    applyStimulus(1'b0); checkOutput("relock_dn1", 32'(sw), 32'd101);
    applyStimulus(1'b0); checkOutput("relock_dn2", 32'(sw), 32'd100);

    // Spread spectrum: depth 2, 4 cycles per step, base 100.
    ssEn     = 1'b1;
    ssDepth  = 4'd2;
    ssPeriod = 8'd3;
    for (int i = 1; i <= 30; i++) begin
      tick();
      checkOutput($sformatf("ss_cyc%0d", i), 32'(sw), 32'(100 + SS_ON * triTbl[(i / 4) % 8]));
    end
    fllLocked = 1'b0;
    tick();
    checkOutput("ss_unlock", 32'(sw), 32'd100);

    // Re-enter TRACK, run into the first offset step, then reset asynchronously.
    fllLocked = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      tick();
      checkOutput($sformatf("ss2_cyc%0d", i), 32'(sw), 32'(100 + SS_ON * triTbl[(i / 4) % 8]));
    end
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_sw", 32'(sw), 32'd128);
    checkOutput("async_rst_valid", 32'(swValid), 32'd0);
    checkOutput("async_rst_max", 32'(atMax), 32'd0);
    #2;
    reset = 1'b1;

    // After release the triangle phase restarts from zero.
    tick();
    checkOutput("rel_acq_sw", 32'(sw), 32'd128);
    checkOutput("rel_acq_valid", 32'(swValid), 32'd1);
    tick();
    checkOutput("rel_track_sw", 32'(sw), 32'd128);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checkOutput($sformatf("ss3_cyc%0d", i), 32'(sw), 32'(128 + SS_ON * triTbl[(i / 4) % 8]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dco_code_ctrl.md
DCO_CODE_CTRL -- requirements
Module: dco_code_ctrl

Interface
REQ-001 SHALL provide parameter SW_W, default 8, width of the DCO switch code.
REQ-002 SHALL provide parameter SW_INIT, default 128, switch code loaded at reset.
REQ-003 SHALL provide parameter HYST, default 2, number of consecutive same-direction updates needed per step in TRACK.
REQ-004 SHALL have port ref_clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port freq_update, input, 1: one-cycle pulse from the frequency loop; a correction is requested.
REQ-007 SHALL have port freq_incr_decr, input, 1: correction direction, 1 = raise frequency (code +1), 0 = lower (code -1); sampled only with freq_update.
REQ-008 SHALL have port fll_locked, input, 1: frequency-loop lock indication, level.
REQ-009 SHALL have port ss_en, input, 1: spread-spectrum enable.
REQ-010 SHALL have port ss_depth, input, 4: triangle amplitude in code LSBs.
REQ-011 SHALL have port ss_period, input, 8: cycles per triangle step, minus 1.
REQ-012 SHALL have port sw, output, SW_W: registered DCO switch code to lc_dco.
REQ-013 SHALL have port sw_valid, output, 1: sw is tracking, not the reset value.
REQ-014 SHALL have port at_min and port at_max, output, 1 each: base code saturated at 0 and at 2^SW_W-1 respectively.

Function
REQ-015 SHALL implement FSM states IDLE, ACQ and TRACK.
- IDLE->ACQ unconditionally after one cycle.
- ACQ->TRACK when fll_locked=1.
- TRACK->ACQ when fll_locked=0.
REQ-016 In ACQ, each freq_update SHALL step the base code by ±1, applied on sw the cycle after the pulse (1-cycle latency).
REQ-017 In TRACK, a step SHALL be applied only after HYST consecutive freq_update pulses of the same direction; a direction change SHALL reset the run count to 1; after a step the count SHALL clear to 0.
REQ-018 The base code SHALL saturate at 0 and 2^SW_W-1 with no wrap; at_min and at_max SHALL reflect the registered base code.
REQ-019 A freq_update in IDLE SHALL be ignored.
REQ-020 freq_update coincident with the ACQ<->TRACK transition SHALL be processed under the rules of the state being left.
REQ-021 Leaving TRACK SHALL clear the hysteresis count.
REQ-022 sw_valid SHALL be 1 in ACQ and TRACK, 0 in IDLE.
REQ-023 sw SHALL equal the base code, saturated, plus the spread offset (REQ-028..030).

Reset
REQ-024 Reset assertion SHALL asynchronously force state=IDLE, base code=SW_INIT, hysteresis count=0, offset=0, sw=SW_INIT, sw_valid=0, at_min=(SW_INIT==0), at_max=(SW_INIT==2^SW_W-1).
REQ-025 Reset asserted mid-operation SHALL discard any partial hysteresis run and triangle phase.
REQ-026 Deassertion SHALL be synchronous in effect: the first state change occurs on the first rising edge of ref_clk after release.

Configuration
REQ-027 Macro SS_MOD_EN SHALL compile in the spread-spectrum modulator.
REQ-028 With SS_MOD_EN defined, a signed triangle offset SHALL run in TRACK when ss_en=1.
- Offset steps ±1 every ss_period+1 cycles.
- Direction reverses on reaching +ss_depth or -ss_depth.
- Offset starts at 0 rising.
REQ-029 With SS_MOD_EN defined, when ss_en=0 or state is not TRACK, the offset SHALL return to 0 immediately (next cycle) and the period counter SHALL clear; ss_depth=0 SHALL hold offset at 0.
REQ-030 Without SS_MOD_EN, the offset SHALL be constant 0, ss_en, ss_depth and ss_period SHALL be ignored, and no modulator logic SHALL be present.

Verification
REQ-031 Reset with SW_INIT=128, release, 3 pulses with freq_incr_decr=1 in ACQ -> sw=131, each change 1 cycle after its pulse, sw_valid=1.
REQ-032 Base code 254, 4 increment pulses in ACQ -> sw=255 and stays 255, at_max=1.
REQ-033 TRACK, HYST=2, pulse sequence up, down, down, up -> one decrement only, from the second down.
REQ-034 SS_MOD_EN defined, TRACK, base 100, ss_en=1, ss_depth=2, ss_period=3 -> sw sequence 100,101,102,101,100,99,98,99,..., each value held 4 cycles; deassert fll_locked -> sw=100 next cycle.
REQ-035 Assert reset mid-run of REQ-034 -> sw=SW_INIT and sw_valid=0 immediately, without waiting for a clock edge.
REQ-036 SS_MOD_EN undefined, same stimulus as REQ-034 -> sw constant 100.
